// File: rtl/iref_setup_pkg.sv
// ---------------------------------------------------------------------------
// iref_setup_pkg
// Shared types and helpers for the multi-channel I_REF setup sequencer.
//   state_t     : sequencer FSM states
//   CODE_MAX_F  : full-scale code for a given code width
//   lane_lo     : low bit index of lane c in a packed per-channel bus
// ---------------------------------------------------------------------------
package iref_setup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic int CODE_MAX_F(input int width);
        return (1 << width) - 1;
    endfunction

    // Channel c of a packed bus lives at [lane_lo(c, width) +: width].
    function automatic int lane_lo(input int c, input int width);
        return c * width;
    endfunction

endpackage

// File: rtl/iref_out_mux.sv
// ---------------------------------------------------------------------------
// iref_out_mux
// Output select for one I_REF DAC lane.
//   i_active    : this lane is the one currently being ramped
//   i_code      : live ramp code
//   i_completed : lane finished its trim (pass or fail)
//   i_use_trim  : completed lanes drive the trim code instead of i_ref
//   i_trim      : latched trim code for this lane
//   i_ref       : externally supplied normal I_REF for this lane
//   o_code      : code driven to the DAC
// ---------------------------------------------------------------------------
module iref_out_mux #(
    parameter int WIDTH = 10
) (
    input  logic             i_active,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_completed,
    input  logic             i_use_trim,
    input  logic [WIDTH-1:0] i_trim,
    input  logic [WIDTH-1:0] i_ref,
    output logic [WIDTH-1:0] o_code
);

    always_comb begin
        o_code = i_ref;
        if (i_active) begin
            o_code = i_code;
        end else if (i_completed && i_use_trim) begin
            o_code = i_trim;
        end
    end

endmodule

// File: rtl/iref_setup_seq.sv
// ---------------------------------------------------------------------------
// iref_setup_seq
// Multi-channel I_REF setup sequencer. On start_i each channel is trimmed in
// turn: its setup code ramps down from full scale in STEP decrements, with
// SETTLE_CYC cycles of settling before every comparator sample, until the
// channel's comparator trips (code latched) or the next step would drop below
// CODE_MIN (CODE_MIN latched, fail flagged).
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : pulse, starts a full run from IDLE or DONE
//   abort_i      : level, returns to IDLE from any state (beats start_i)
//   use_trim_i   : completed channels drive trim code (1) or i_ref (0)
//   i_ref        : per-channel normal I_REF, packed N_CH x WIDTH
//   cmp_i        : per-channel comparator, 1 = target reached (pre-synced)
//   i_ref_out    : per-channel DAC code
//   trim_code_o  : latched trim codes
//   completed    : channel finished (pass or fail)
//   fail_o       : channel hit CODE_MIN without a trip
//   busy_o       : sequencer ramping (SETTLE/CHECK/NEXT)
//   done_o       : level, high in DONE
// ---------------------------------------------------------------------------
module iref_setup_seq
    import iref_setup_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int N_CH       = 4,
    parameter int STEP       = 8,
    parameter int SETTLE_CYC = 4,
    parameter int CODE_MIN   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  use_trim_i,
    input  logic [N_CH*WIDTH-1:0] i_ref,
    input  logic [N_CH-1:0]       cmp_i,
    output logic [N_CH*WIDTH-1:0] i_ref_out,
    output logic [N_CH*WIDTH-1:0] trim_code_o,
    output logic [N_CH-1:0]       completed,
    output logic [N_CH-1:0]       fail_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [WIDTH-1:0] CODE_MAX   = WIDTH'(CODE_MAX_F(WIDTH));
    localparam logic [WIDTH-1:0] CODE_MIN_W = WIDTH'(CODE_MIN);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    // code - STEP < CODE_MIN rewritten as code < CODE_MIN + STEP, one bit
    // wider so neither side can wrap.
    localparam logic [WIDTH:0]   FAIL_BELOW = (WIDTH+1)'(CODE_MIN + STEP);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [WIDTH-1:0]      r_code;
    logic [CNT_W-1:0]      r_cnt;
    logic [N_CH*WIDTH-1:0] r_trim;
    logic [N_CH-1:0]       r_completed;
    logic [N_CH-1:0]       r_fail;
    logic                  r_busy;
    logic                  r_done;

    logic w_cmp;
    logic w_underflow;

    assign w_cmp       = cmp_i[r_ch];
    assign w_underflow = ({1'b0, r_code} < FAIL_BELOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_code      <= CODE_MAX;
            r_cnt       <= '0;
            r_trim      <= '0;
            r_completed <= '0;
            r_fail      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort_i) begin
            // Finished channels keep their results; the rest stay cleared.
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_code  <= CODE_MAX;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_completed <= '0;
                        r_fail      <= '0;
                        r_ch        <= '0;
                        r_code      <= CODE_MAX;
                        r_cnt       <= CNT_LOAD;
                        r_state     <= ST_SETTLE;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_cmp) begin
                        r_trim[lane_lo(int'(r_ch), WIDTH) +: WIDTH] <= r_code;
                        r_completed[r_ch] <= 1'b1;
                        r_state           <= ST_NEXT;
                    end else if (w_underflow) begin
                        r_trim[lane_lo(int'(r_ch), WIDTH) +: WIDTH] <= CODE_MIN_W;
                        r_fail[r_ch]      <= 1'b1;
                        r_completed[r_ch] <= 1'b1;
                        r_state           <= ST_NEXT;
                    end else begin
                        r_code  <= r_code - STEP_W;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_NEXT: begin
                    if (r_ch == CH_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_code  <= CODE_MAX;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign trim_code_o = r_trim;
    assign completed   = r_completed;
    assign fail_o      = r_fail;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        logic w_active;
        assign w_active = r_busy && (r_ch == CH_W'(c));

        iref_out_mux #(
            .WIDTH(WIDTH)
        ) u_mux (
            .i_active    (w_active),
            .i_code      (r_code),
            .i_completed (r_completed[c]),
            .i_use_trim  (use_trim_i),
            .i_trim      (r_trim[lane_lo(c, WIDTH) +: WIDTH]),
            .i_ref       (i_ref[lane_lo(c, WIDTH) +: WIDTH]),
            .o_code      (i_ref_out[lane_lo(c, WIDTH) +: WIDTH])
        );
    end

endmodule
